// File: rtl/multdiv_if.sv
// Handshake and data bundle between a requester and the multdiv_ctrl sequencer.
interface multdiv_if;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Iterative 32-bit signed multiply (radix-2 Booth) / divide (non-restoring),
// both sequenced over one shared adder/subtractor.
module multdiv_ctrl (
    input logic      clock,
    input logic      reset_n,
    multdiv_if.slave bus
);
    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_e;

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic [31:0] acc_q;     // Booth accumulator / signed partial remainder
    logic [31:0] q_q;       // multiplier bits / dividend magnitude -> quotient
    logic        q1_q;      // Booth q(-1)
    logic [31:0] m_q;       // multiplicand / raw signed divisor
    logic        div_q;
    logic        neg_q;
    logic        dz_q;
    logic [31:0] result_q;
    logic        exc_q;
    logic        rdy_q;
    logic        busy_q;

    logic [31:0] add_a, add_b, add_bx, sum;
    logic        add_sub, cout;

    // In IDLE the adder negates operand A (dividend magnitude), in DONE it
    // negates the quotient, so sign handling needs no extra adder either.
    always_comb begin
        add_a   = '0;
        add_b   = bus.data_operandA;
        add_sub = 1'b1;
        case (state_q)
            MULT: begin
                add_a   = acc_q;
                add_b   = m_q;
                add_sub = q_q[0] & ~q1_q;
            end
            DIV: begin
                // The divisor stays signed: adding a negative divisor is the
                // same as subtracting its magnitude, modulo 2^32.
                add_a   = {acc_q[30:0], q_q[31]};
                add_b   = m_q;
                add_sub = ~acc_q[31] ^ m_q[31];
            end
            DONE: begin
                add_a   = '0;
                add_b   = q_q;
                add_sub = 1'b1;
            end
            default: ;
        endcase
    end

    assign add_bx      = add_sub ? ~add_b : add_b;
    assign {cout, sum} = {1'b0, add_a} + {1'b0, add_bx} + {32'd0, add_sub};

    // Booth sum can need 33 bits (e.g. 0 - 0x80000000); recover the true
    // sign from the carry so the arithmetic shift stays exact.
    logic        booth_op;
    logic        booth_top;
    logic [31:0] booth_s;
    assign booth_op  = q_q[0] ^ q1_q;
    assign booth_top = booth_op ? (add_a[31] ^ add_bx[31] ^ cout) : acc_q[31];
    assign booth_s   = booth_op ? sum : acc_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            q1_q     <= 1'b0;
            m_q      <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    rdy_q <= 1'b0;
                    cnt_q <= '0;
                    if (bus.ctrl_MULT) begin
                        state_q <= MULT;
                        busy_q  <= 1'b1;
                        div_q   <= 1'b0;
                        acc_q   <= '0;
                        q_q     <= bus.data_operandB;
                        q1_q    <= 1'b0;
                        m_q     <= bus.data_operandA;
                    end else if (bus.ctrl_DIV) begin
                        state_q <= DIV;
                        busy_q  <= 1'b1;
                        div_q   <= 1'b1;
                        acc_q   <= '0;
                        q_q     <= bus.data_operandA[31] ? sum : bus.data_operandA;
                        q1_q    <= 1'b0;
                        m_q     <= bus.data_operandB;
                        neg_q   <= bus.data_operandA[31] ^ bus.data_operandB[31];
                        dz_q    <= (bus.data_operandB == 32'd0);
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                MULT: begin
                    {acc_q, q_q, q1_q} <= {booth_top, booth_s, q_q};
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= DONE;
                end
                DIV: begin
                    // Quotient bits come out exact; the remainder is never
                    // exported, so it is left uncorrected.
                    acc_q <= sum;
                    q_q   <= {q_q[30:0], ~sum[31]};
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'd31) state_q <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                    if (!div_q) begin
                        result_q <= q_q;
                        exc_q    <= (acc_q != {32{q_q[31]}});
                    end else if (dz_q) begin
                        result_q <= '0;
                        exc_q    <= 1'b1;
                    end else begin
                        result_q <= neg_q ? sum : q_q;
                        exc_q    <= ~neg_q & q_q[31];
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Randomised + directed bench for multdiv_ctrl against a transaction-level model.
module tb_multdiv_ctrl;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    multdiv_if bus();
    multdiv_ctrl dut (.clock(clock), .reset_n(reset_n), .bus(bus));

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %09h expected %09h at %0t", name, act, exp, $time);
    endtask

    // Reference result {exception, result} from plain signed arithmetic.
    function automatic logic [32:0] ref_op(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        longint      p;
        logic [31:0] r;
        logic        e;
        if (is_mult) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(r)));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
            r = 32'h80000000;
            e = 1'b1;
        end else begin
            p = longint'($signed(a)) / longint'($signed(b));
            r = p[31:0];
            e = 1'b0;
        end
        return {e, r};
    endfunction

    // Model: m_left counts remaining busy cycles; 1 means the ready cycle.
    int          m_left   = 0;
    logic [31:0] exp_res  = '0;
    logic        exp_exc  = 1'b0;
    logic [31:0] pend_res = '0;
    logic        pend_exc = 1'b0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_left  <= 0;
            exp_res <= '0;
            exp_exc <= 1'b0;
        end else if (m_left > 1) begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                exp_res <= pend_res;
                exp_exc <= pend_exc;
            end
        end else if (bus.ctrl_MULT || bus.ctrl_DIV) begin
            {pend_exc, pend_res} <= ref_op(bus.ctrl_MULT, bus.data_operandA, bus.data_operandB);
            m_left <= 34;
        end else begin
            m_left <= 0;
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            chk("rdy",    33'(bus.data_resultRDY), 33'(m_left == 1));
            chk("busy",   33'(bus.busy),           33'(m_left != 0));
            chk("result", 33'(bus.data_result),    33'(exp_res));
            chk("exc",    33'(bus.data_exception), 33'(exp_exc));
        end
    end

    // Called at a negedge: drives the start, waits (bounded) for ready.
    task automatic run_op(input string name, input bit mul, input bit dv,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input bit ee,
                          input int pulse_at, input bit pre_start);
        int k;
        bus.ctrl_MULT = mul;
        bus.ctrl_DIV  = dv;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
        k = 1;
        while (!bus.data_resultRDY && k < 40) begin
            bus.ctrl_DIV = (k == pulse_at);
            if (pre_start && k == 33) begin
                bus.ctrl_MULT = 1'b1;
                bus.data_operandA = 32'd1000;
                bus.data_operandB = 32'd1000;
            end
            @(negedge clock);
            k++;
        end
        bus.ctrl_DIV = 1'b0;
        chk({name, " latency"}, 33'(k), 33'd34);
        chk({name, " result"},  33'(bus.data_result), 33'(er));
        chk({name, " exc"},     33'(bus.data_exception), 33'(ee));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h80000000;
            2: return 32'hFFFFFFFF;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (2) @(posedge clock);
        #1 chk_en = 1'b1;
        chk("reset result", 33'(bus.data_result), 33'd0);
        chk("reset rdy/busy/exc", 33'({bus.data_resultRDY, bus.busy, bus.data_exception}), 33'd0);

        // Pin the reference model to hand-computed values.
        chk("ref 7*-3",      ref_op(1'b1, 32'd7, 32'hFFFFFFFD),          {1'b0, 32'hFFFFFFEB});
        chk("ref 2^16*2^16", ref_op(1'b1, 32'h00010000, 32'h00010000),   {1'b1, 32'h00000000});
        chk("ref min*-1",    ref_op(1'b1, 32'h80000000, 32'hFFFFFFFF),   {1'b1, 32'h80000000});
        chk("ref -7/2",      ref_op(1'b0, 32'hFFFFFFF9, 32'd2),          {1'b0, 32'hFFFFFFFD});
        chk("ref 5/0",       ref_op(1'b0, 32'd5, 32'd0),                 {1'b1, 32'h00000000});
        chk("ref min/-1",    ref_op(1'b0, 32'h80000000, 32'hFFFFFFFF),   {1'b1, 32'h80000000});

        @(negedge clock);
        reset_n = 1'b1;
        run_op("m 7*-3",   1, 0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 0, 0);
        run_op("m ovf",    1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1, 0, 0);
        run_op("m min*-1", 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 0);
        run_op("d -7/2",   0, 1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0, 0);
        run_op("d 5/0",    0, 1, 32'd5,        32'd0,        32'h00000000, 1, 0, 0);
        run_op("d min/-1", 0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 0);
        // Both starts high: multiply wins; mid-op DIV pulse ignored; a start
        // sampled on the ready-rising edge is dropped.
        run_op("both 6,3", 1, 1, 32'd6,        32'd3,        32'd18,       0, 10, 1);
        run_op("b2b 2*5",  1, 0, 32'd2,        32'd5,        32'd10,       0, 0, 0);
        @(negedge clock);
        chk("single rdy", 33'(bus.data_resultRDY), 33'd0);

        // Asynchronous reset in the middle of an operation.
        bus.ctrl_MULT = 1'b1;
        bus.data_operandA = 32'd123;
        bus.data_operandB = 32'd456;
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        repeat (15) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("mid-rst result", 33'(bus.data_result), 33'd0);
        chk("mid-rst flags",  33'({bus.data_resultRDY, bus.busy, bus.data_exception}), 33'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        run_op("post-rst 2*3", 1, 0, 32'd2, 32'd3, 32'd6, 0, 0, 0);

        // Random traffic; the compare process checks every cycle.
        repeat (3000) begin
            @(negedge clock);
            case ($urandom_range(0, 15))
                0:       begin bus.ctrl_MULT = 1'b1; bus.ctrl_DIV = 1'b0; end
                1, 2:    begin bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b1; end
                3:       begin bus.ctrl_MULT = 1'b1; bus.ctrl_DIV = 1'b1; end
                default: begin bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0; end
            endcase
            bus.data_operandA = pick();
            bus.data_operandB = pick();
        end
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV  = 1'b0;
        repeat (40) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
